seq_divider: RTL and testbench

Multi-cycle iterative divider (radix-2 restoring) with a valid/ready handshake on both sides. Supports signed and unsigned operation per request, and flags divide-by-zero and signed overflow with defined results instead of X. Successor to the single-cycle divider: it removes the M-bit combinational divide from the timing path at the cost of M+2 cycles of latency. It sits between the ALU issue stage and the writeback arbiter.

---
 rtl/div_pkg.sv | 26 ++
 rtl/seq_divider_if.sv | 33 +++
 rtl/div_restoring_step.sv | 22 ++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Most negative two's-complement value of width w (w <= 64).
  function automatic logic [63:0] signed_min(input int unsigned w);
    signed_min = 64'(1) << (w - 1);
  endfunction

  typedef struct packed {
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;
  } div_result_t;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result handshake bundle between issue stage, divider and writeback.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int unsigned M     = DIV_W,
  parameter int unsigned TAG_W = DIV_TAG_W
) ();

  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [M-1:0]     dividend;
  logic [M-1:0]     divisor;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [M-1:0]     quotient;
  logic [M-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, is_signed, dividend, divisor, in_tag, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_tag
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, in_tag, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, out_tag
  );

endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restoring_step
  import div_pkg::*;
#(
  parameter int unsigned M = DIV_W
) (
  input  logic [M:0]   prem,
  input  logic         dvd_bit,
  input  logic [M-1:0] dvs,
  output logic [M:0]   prem_nxt_c,
  output logic         qbit_c
);

  logic [M+1:0] shifted;
  logic [M+1:0] diff;

  assign shifted    = {prem, dvd_bit};
  assign diff       = shifted - {2'b00, dvs};
  assign qbit_c     = ~diff[M+1];
  assign prem_nxt_c = qbit_c ? diff[M:0] : shifted[M:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned M     = DIV_W,
  parameter int unsigned TAG_W = DIV_TAG_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(M);
  localparam logic [M-1:0] MIN_VAL = M'(signed_min(M));

  div_state_t       state_q, state_d;
  logic [M-1:0]     dvd_q, dvs_q, quo_q;
  logic [M:0]       prem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, dz_q, ov_q;
  logic [TAG_W-1:0] tag_q;
  div_result_t      res_q;
  logic             out_valid_q, in_ready_q;

  logic             accept_c, handoff_c, zero_c, ovf_c, dvd_neg_c, dvs_neg_c;
  logic [M:0]       prem_nxt_c;
  logic             qbit_c;

  assign accept_c  = bus.in_valid && in_ready_q;
  assign handoff_c = out_valid_q && bus.out_ready;
  assign zero_c    = (bus.divisor == '0);
  assign ovf_c     = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
  assign dvd_neg_c = bus.is_signed && bus.dividend[M-1];
  assign dvs_neg_c = bus.is_signed && bus.divisor[M-1];

  div_restoring_step #(.M(M)) u_step (
    .prem       (prem_q),
    .dvd_bit    (dvd_q[M-1]),
    .dvs        (dvs_q),
    .prem_nxt_c (prem_nxt_c),
    .qbit_c     (qbit_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Special cases take the FIX hop too, so every result is loaded by one path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = (zero_c || ovf_c) ? FIX : BUSY;
      BUSY:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (handoff_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      ov_q        <= 1'b0;
      tag_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      in_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: if (accept_c) begin
          tag_q   <= bus.in_tag;
          cnt_q   <= CNT_W'(M - 1);
          dz_q    <= zero_c;
          ov_q    <= ovf_c;
          quo_q   <= '0;
          prem_q  <= '0;
          q_neg_q <= 1'b0;
          r_neg_q <= 1'b0;
          if (zero_c) begin
            quo_q  <= '1;
            prem_q <= {1'b0, bus.dividend};
          end else if (ovf_c) begin
            quo_q  <= MIN_VAL;
          end else begin
            dvd_q   <= dvd_neg_c ? -bus.dividend : bus.dividend;
            dvs_q   <= dvs_neg_c ? -bus.divisor  : bus.divisor;
            q_neg_q <= dvd_neg_c ^ dvs_neg_c;
            r_neg_q <= dvd_neg_c;
          end
        end
        BUSY: begin
          prem_q <= prem_nxt_c;
          dvd_q  <= {dvd_q[M-2:0], 1'b0};
          quo_q  <= {quo_q[M-2:0], qbit_c};
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        FIX: begin
          res_q.quotient    <= DIV_W'(q_neg_q ? -quo_q : quo_q);
          res_q.remainder   <= DIV_W'(r_neg_q ? -prem_q[M-1:0] : prem_q[M-1:0]);
          res_q.div_by_zero <= dz_q;
          res_q.overflow    <= ov_q;
          out_valid_q       <= 1'b1;
        end
        DONE: if (handoff_c) begin
          out_valid_q       <= 1'b0;
          res_q.div_by_zero <= 1'b0;
          res_q.overflow    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = M'(res_q.quotient);
  assign bus.remainder   = M'(res_q.remainder);
  assign bus.div_by_zero = res_q.div_by_zero;
  assign bus.overflow    = res_q.overflow;
  assign bus.out_tag     = tag_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: sign cases, specials, backpressure, mid-op reset.
module tb_seq_divider;

  localparam int unsigned M  = 32;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.M(M), .TAG_W(TW)) bus ();

  seq_divider #(.M(M), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tg);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_tag    = tg;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.is_signed = ~sgn;
    bus.dividend  = 32'hDEAD_BEEF;
    bus.divisor   = 32'h0000_0003;
    bus.in_tag    = ~tg;
  endtask

  task automatic run(input string nm, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [3:0] tg,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic ez, input logic eo, input int elat, input int hold);
    int   lat;
    logic ir_low;
    chk({nm, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = (hold == 0);
    start(sgn, a, b, tg);
    lat    = 0;
    ir_low = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ir_low = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, ".latency"}, 64'(lat), 64'(elat));
    chk({nm, ".busy_ready"}, 64'(ir_low), 64'd1);
    chk({nm, ".q"}, 64'(bus.quotient), 64'(eq));
    chk({nm, ".r"}, 64'(bus.remainder), 64'(er));
    chk({nm, ".dz"}, 64'(bus.div_by_zero), 64'(ez));
    chk({nm, ".ov"}, 64'(bus.overflow), 64'(eo));
    chk({nm, ".tag"}, 64'(bus.out_tag), 64'(tg));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({nm, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nm, ".hold_q"}, 64'(bus.quotient), 64'(eq));
      chk({nm, ".hold_r"}, 64'(bus.remainder), 64'(er));
      chk({nm, ".hold_flags"}, 64'({bus.div_by_zero, bus.overflow}), 64'({ez, eo}));
      chk({nm, ".hold_tag"}, 64'(bus.out_tag), 64'(tg));
      chk({nm, ".hold_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, ".post_valid"}, 64'(bus.out_valid), 64'd0);
    chk({nm, ".post_ready"}, 64'(bus.in_ready), 64'd1);
    chk({nm, ".post_flags"}, 64'({bus.div_by_zero, bus.overflow}), 64'd0);
  endtask

  initial begin
    logic seen;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.q", 64'(bus.quotient), 64'd0);
    chk("rst.r", 64'(bus.remainder), 64'd0);
    chk("rst.flags", 64'({bus.div_by_zero, bus.overflow}), 64'd0);
    chk("rst.tag", 64'(bus.out_tag), 64'd0);

    // name, signed, dividend, divisor, tag, q, r, dz, ov, latency, hold
    run("s100_7",   1'b1, 32'd100,       32'd7,         4'h1, 32'd14,        32'd2,         1'b0, 1'b0, 33, 0);
    run("sm100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         4'h2, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
    run("s100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 4'h3, 32'hFFFF_FFF2, 32'd2,         1'b0, 1'b0, 33, 0);
    run("sm100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 4'h4, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
    run("u_ff_2",   1'b0, 32'hFFFF_FFFF, 32'd2,         4'h5, 32'h7FFF_FFFF, 32'd1,         1'b0, 1'b0, 33, 0);
    run("s_m1_2",   1'b1, 32'hFFFF_FFFF, 32'd2,         4'h6, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 33, 0);
    run("div0",     1'b0, 32'd7,         32'd0,         4'h7, 32'hFFFF_FFFF, 32'd7,         1'b1, 1'b0, 1,  0);
    run("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 32'h8000_0000, 32'd0,         1'b0, 1'b1, 1,  0);
    run("u_min_ff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 32'd0,         32'h8000_0000, 1'b0, 1'b0, 33, 0);
    run("s_min_3",  1'b1, 32'h8000_0000, 32'd3,         4'hB, 32'hD555_5556, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 0);
    run("u_eq",     1'b0, 32'd1000,      32'd1000,      4'hC, 32'd1,         32'd0,         1'b0, 1'b0, 33, 0);
    run("bp",       1'b1, 32'd100,       32'd7,         4'hA, 32'd14,        32'd2,         1'b0, 1'b0, 33, 5);

    // Reset lands in the middle of an iteration.
    start(1'b1, 32'd1000, 32'd7, 4'h5);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst.q", 64'(bus.quotient), 64'd0);
    chk("midrst.r", 64'(bus.remainder), 64'd0);
    chk("midrst.tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst.no_output", 64'(seen), 64'd0);
    run("after_rst", 1'b1, 32'd9, 32'd3, 4'hD, 32'd3, 32'd0, 1'b0, 1'b0, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
